mem_stage: RTL

Memory-access stage of the five-stage RV32I pipeline, sitting between the EX/MEM pipeline latch and the MEM/WB latch. It converts the latched ALU address, store data, funct3 and byte position into a data-memory request with byte enables. It holds that request across a multi-cycle `dmem_resp` handshake and raises a pipeline stall while the access is outstanding. It returns aligned, sign- or zero-extended load data, and captures it if the pipeline is frozen by another stage when the response arrives.

---
 rtl/mem_stage_pkg.sv | 26 ++
 rtl/mem_stage_load_store_align.sv | 50 +++++
 rtl/mem_stage.sv | 104 ++++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types and funct3 encodings for the RV32I memory-access stage.
package mem_stage_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } mem_state_t;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   // Halfwords need byte_pos[0]=0 and words need byte_pos=0; funct3[2] is only the sign bit.
   function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] byte_pos);
      return ((funct3[1:0] == 2'b01) && byte_pos[0]) ||
             ((funct3[1:0] == 2'b10) && (byte_pos != 2'b00));
   endfunction

endpackage

// File: rtl/mem_stage_load_store_align.sv
// Combinational lane steering: byte enables and replicated store data, plus load extraction/extension.
module load_store_align
   import mem_stage_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  byte_pos,
   input  logic        is_store,
   input  logic [31:0] rs2,
   input  logic [31:0] rdata,
   output logic [3:0]  mbe,
   output logic [31:0] wdata,
   output logic [31:0] load_data
);

   logic [31:0] byte_sh;
   logic [15:0] half_sel;

   always_comb begin
      byte_sh   = rdata >> {byte_pos, 3'b000};
      half_sel  = byte_pos[1] ? rdata[31:16] : rdata[15:0];
      mbe       = 4'b1111;
      wdata     = rs2;
      load_data = '0;

      if (is_store) begin
         case (funct3)
            F3_SB: begin
               mbe   = 4'b0001 << byte_pos;
               wdata = {4{rs2[7:0]}};
            end
            F3_SH: begin
               mbe   = 4'b0011 << {byte_pos[1], 1'b0};
               wdata = {2{rs2[15:0]}};
            end
            F3_SW:   mbe = 4'b1111;
            default: mbe = 4'b0000;
         endcase
      end

      case (funct3)
         F3_LB:   load_data = {{24{byte_sh[7]}}, byte_sh[7:0]};
         F3_LBU:  load_data = {24'd0, byte_sh[7:0]};
         F3_LH:   load_data = {{16{half_sel[15]}}, half_sel};
         F3_LHU:  load_data = {16'd0, half_sel};
         F3_LW:   load_data = rdata;
         default: load_data = '0;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// RV32I MEM stage: issues the dmem request, stalls until dmem_resp, returns extended load data.
// Optional MISALIGN_TRAP_EN suppresses misaligned halfword/word accesses and flags them on misalign.
module mem_stage
   import mem_stage_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        exmem_valid,
   input  logic        exmem_mem_read,
   input  logic        exmem_mem_write,
   input  logic [2:0]  exmem_funct3,
   input  logic [31:0] exmem_aluout,
   input  logic [31:0] exmem_rs2,
   input  logic        pipe_advance,
   output logic [31:0] dmem_address,
   output logic        dmem_read,
   output logic        dmem_write,
   output logic [3:0]  dmem_mbe,
   output logic [31:0] dmem_wdata,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_resp,
   output logic        mem_stall,
   output logic [31:0] load_data,
   output logic        misalign
);

   mem_state_t  state_q, state_d;
   logic [31:0] cap_q, cap_d;

   logic        mem_op, mis, issue, in_busy, in_done, req, resp_cyc;
   logic [1:0]  byte_pos;
   logic [3:0]  al_mbe;
   logic [31:0] al_wdata, al_load, al_rdata;

   assign byte_pos = exmem_aluout[1:0];
   assign mem_op   = exmem_valid & (exmem_mem_read | exmem_mem_write);

`ifdef MISALIGN_TRAP_EN
   assign mis = mem_op & is_misaligned(exmem_funct3, byte_pos);
`else
   assign mis = 1'b0;
`endif

   assign in_busy  = (state_q == BUSY);
   assign in_done  = (state_q == DONE);
   assign issue    = (state_q == IDLE) & mem_op & ~mis;
   assign req      = issue | in_busy;
   assign resp_cyc = in_busy & dmem_resp;
   // In DONE the pipeline is frozen, so funct3/byte_pos still describe the captured word.
   assign al_rdata = in_done ? cap_q : dmem_rdata;

   load_store_align u_align (
      .funct3    (exmem_funct3),
      .byte_pos  (byte_pos),
      .is_store  (exmem_mem_write),
      .rs2       (exmem_rs2),
      .rdata     (al_rdata),
      .mbe       (al_mbe),
      .wdata     (al_wdata),
      .load_data (al_load)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cap_q   <= '0;
      end else begin
         state_q <= state_d;
         cap_q   <= cap_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cap_d   = cap_q;
      case (state_q)
         IDLE: if (issue) state_d = BUSY;
         BUSY: begin
            if (dmem_resp) begin
               if (pipe_advance) begin
                  state_d = IDLE;
               end else begin
                  state_d = DONE;
                  cap_d   = dmem_rdata;
               end
            end
         end
         DONE: if (pipe_advance) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      dmem_address = {exmem_aluout[31:2], 2'b00};
      dmem_read    = rst & req & exmem_mem_read & ~exmem_mem_write;
      dmem_write   = rst & req & exmem_mem_write;
      dmem_mbe     = req ? al_mbe : 4'b0000;
      dmem_wdata   = al_wdata;
      mem_stall    = rst & (issue | (in_busy & ~dmem_resp));
      misalign     = rst & mis & (state_q == IDLE);
      load_data    = (rst & (resp_cyc | in_done)) ? al_load : 32'd0;
   end

endmodule
